// File: rtl/seg7_btn_sched.sv
// Button sync/debounce, one-deep press queue and round-robin display scheduler.
// Define SEG7_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module seg7_btn_sched #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] grant,
    output logic [1:0] active_btn,
    output logic [3:0] digit,
    output logic       seg_en,
    output logic       busy,
    output logic       drop_flag
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_SHOW
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync1_q;
    logic [3:0]       btn_s_q;
    logic [3:0]       stable_q;
    logic [3:0]       stable_prev_q;
    logic [CNT_W-1:0] db_cnt_q [4];
    logic [3:0]       pend_q, pend_d;
    logic             drop_q, drop_d;
    logic [3:0]       pcnt_q [4];
    logic [1:0]       act_q;
    logic [CNT_W-1:0] hold_q;
    logic [3:0]       digit_q;
    logic [3:0]       press;
    logic [3:0]       clr;
    logic [1:0]       win;
    logic [3:0]       pcnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            btn_s_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q       <= btn_raw;
            btn_s_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 4; i++) begin
                if (btn_s_q[i] != stable_q[i]) begin
                    if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        stable_q[i] <= btn_s_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;
    assign clr   = (state_q == S_GRANT) ? (4'b0001 << act_q) : 4'b0000;

    // A new press wins over the grant-time clear of the same bit.
    always_comb begin
        pend_d = (pend_q & ~clr) | press;
        drop_d = drop_q | (|(press & pend_q & ~clr));
    end

`ifdef SEG7_FIXED_PRIO_EN
    always_comb begin
        win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pend_q[k]) win = 2'(k);
        end
    end
`else
    logic [1:0] ptr_q;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && pend_q[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (state_q == S_GRANT) begin
            ptr_q <= act_q + 2'd1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (|pend_q) state_d = S_GRANT;
            S_GRANT: state_d = S_SHOW;
            S_SHOW:  if (hold_q == CNT_W'(HOLD_CYCLES - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign pcnt_nxt = (pcnt_q[act_q] == 4'd9) ? 4'd0 : pcnt_q[act_q] + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            drop_q  <= 1'b0;
            act_q   <= '0;
            hold_q  <= '0;
            digit_q <= '0;
            for (int i = 0; i < 4; i++) pcnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            if (state_q == S_IDLE && |pend_q) act_q <= win;
            if (state_q == S_GRANT) begin
                pcnt_q[act_q] <= pcnt_nxt;
                digit_q       <= pcnt_nxt;
                hold_q        <= '0;
            end
            if (state_q == S_SHOW) hold_q <= hold_q + 1'b1;
        end
    end

    assign grant      = (state_q == S_GRANT) ? (4'b0001 << act_q) : 4'b0000;
    assign active_btn = act_q;
    assign digit      = digit_q;
    assign seg_en     = (state_q == S_SHOW);
    assign busy       = (state_q != S_IDLE);
    assign drop_flag  = drop_q;

endmodule

// File: tb/tb_seg7_btn_sched.sv
// Randomised and directed bench for seg7_btn_sched against a behavioural model.
module tb_seg7_btn_sched;
    localparam int D = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'h0;
    logic [3:0] grant;
    logic [1:0] active_btn;
    logic [3:0] digit;
    logic       seg_en;
    logic       busy;
    logic       drop_flag;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_btn_sched #(.CNT_W(16), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .grant(grant),
        .active_btn(active_btn), .digit(digit), .seg_en(seg_en),
        .busy(busy), .drop_flag(drop_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sync delay line, run-length debounce, press queue,
    // and a display owner with a countdown window.
    bit s1[4], s2[4], stab[4], prevst[4], pend[4], mdrop;
    int run[4], pc[4];
    int mode, owner, ptr, left, dig;

    function automatic int pick();
        int w = -1;
`ifdef SEG7_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) if (pend[k]) w = k;
`else
        for (int k = 3; k >= 0; k--) if (pend[(ptr + k) % 4]) w = (ptr + k) % 4;
`endif
        return w;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] raw);
        bit rise[4];
        bit pold[4];
        int gw;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                s1[i] = 0; s2[i] = 0; stab[i] = 0; prevst[i] = 0;
                pend[i] = 0; run[i] = 0; pc[i] = 0;
            end
            mdrop = 0; mode = 0; owner = 0; ptr = 0; left = 0; dig = 0;
            return;
        end
        gw = (mode == 1) ? owner : -1;
        for (int i = 0; i < 4; i++) begin
            pold[i]   = pend[i];
            rise[i]   = stab[i] && !prevst[i];
            prevst[i] = stab[i];
            if (s2[i] != stab[i]) begin
                run[i]++;
                if (run[i] == D) begin stab[i] = s2[i]; run[i] = 0; end
            end else run[i] = 0;
            s2[i] = s1[i];
            s1[i] = raw[i];
            if (gw == i) pend[i] = 0;
            if (rise[i]) begin
                if (pold[i] && gw != i) mdrop = 1;
                pend[i] = 1;
            end
        end
        if (mode == 0) begin
            int w;
            for (int i = 0; i < 4; i++) pend[i] = pend[i];
            begin
                bit save[4];
                for (int i = 0; i < 4; i++) begin save[i] = pend[i]; pend[i] = pold[i]; end
                w = pick();
                for (int i = 0; i < 4; i++) pend[i] = save[i];
            end
            if (w >= 0) begin owner = w; mode = 1; end
        end else if (mode == 1) begin
            pc[owner] = (pc[owner] + 1) % 10;
            dig  = pc[owner];
            ptr  = (owner + 1) % 4;
            left = H;
            mode = 2;
        end else begin
            left--;
            if (left == 0) mode = 0;
        end
    endtask

    function automatic logic [31:0] model_out();
        logic [3:0] g;
        g = (mode == 1) ? 4'(1 << owner) : 4'h0;
        return {19'd0, g, 2'(owner), 4'(dig), mode == 2, mode != 0, mdrop};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(rst, btn_raw);
        #1;
        chk("outs", {19'd0, grant, active_btn, digit, seg_en, busy, drop_flag}, model_out());
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    int k, g3, ng, t1, t2;
    logic [3:0] g1v, g2v;
    int dur[4];

    initial begin
        btn_raw = 4'hF;
        do_reset(3);
        chk("rst_grant", grant, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_digit", digit, 4'h0);
        btn_raw = 4'h0;
        repeat (3) tick();

        // clean press latency and window length
        btn_raw = 4'h1;
        k = 0;
        while (grant == 4'h0 && k < 40) begin tick(); k++; end
        chk("latency", k, D + 4);
        chk("grant0", grant, 4'b0001);
        tick();
        chk("digit1", digit, 4'd1);
        k = 1;
        while (busy && k < 40) begin tick(); k++; end
        chk("window", k, H + 1);
        btn_raw = 4'h0;
        repeat (20) tick();

        // bounce then clean hold on button 1
        do_reset(2);
        ng = 0;
        for (int t = 0; t < 60; t++) begin
            btn_raw = {2'b0, (t < 2) || (t >= 4 && t < 7) || (t >= 20 && t < 30), 1'b0};
            tick();
            if (grant != 4'h0) begin ng++; g1v = grant; t1 = t; end
        end
        chk("bounce_cnt", ng, 1);
        chk("bounce_g", g1v, 4'b0010);
        chk("bounce_t", t1, 20 + D + 3);

        // simultaneous buttons 2 and 3
        do_reset(2);
        ng = 0;
        for (int t = 0; t < 60; t++) begin
            btn_raw = (t < 12) ? 4'b1100 : 4'b0000;
            tick();
            if (grant != 4'h0) begin
                if (ng == 0) begin g1v = grant; t1 = t; end
                else begin g2v = grant; t2 = t; end
                ng++;
            end
        end
        chk("sim_cnt", ng, 2);
        chk("sim_first", g1v, 4'b0100);
        chk("sim_second", g2v, 4'b1000);
        chk("sim_gap", t2 - t1, H + 2);

        // digit wrap on button 0
        do_reset(2);
        for (int i = 1; i <= 10; i++) begin
            int cap;
            cap = -1;
            btn_raw = 4'h1;
            repeat (8) begin tick(); if (seg_en && cap < 0) cap = digit; end
            btn_raw = 4'h0;
            repeat (30) begin tick(); if (seg_en && cap < 0) cap = digit; end
            chk("wrap", cap, i % 10);
        end

        // drop: two presses of button 3 while queued behind 0..2
        do_reset(2);
        g3 = 0;
        for (int t = 0; t < 90; t++) begin
            btn_raw[2:0] = (t < 10) ? 3'b111 : 3'b000;
            btn_raw[3]   = (t >= 2 && t < 9) || (t >= 16 && t < 23);
            tick();
            if (grant[3]) g3++;
        end
        chk("drop_flag", drop_flag, 1'b1);
        chk("drop_g3", g3, 1);

        // reset in the middle of a window
        do_reset(2);
        btn_raw = 4'b0010;
        k = 0;
        while (!seg_en && k < 40) begin tick(); k++; end
        chk("mid_show", seg_en, 1'b1);
        btn_raw = 4'h0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mid_seg", seg_en, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_digit", digit, 4'h0);
        tick();
        rst = 1'b0;
        ng = 0;
        repeat (40) begin tick(); if (grant != 4'h0) ng++; end
        chk("mid_nogrant", ng, 0);

        // random soak
        do_reset(2);
        for (int i = 0; i < 4; i++) dur[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (dur[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    dur[i] = $urandom_range(1, 16);
                end
                dur[i]--;
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule

// File: doc/seg7_btn_sched.md
Name: seg7_btn_sched

Overview:
- Sequencing controller between the four raw push-buttons and the seven-segment decoder.
- Synchronises and debounces each button, then turns clean rising edges into one-deep pending press requests.
- Arbitrates pending requests round-robin and runs a small FSM. The FSM grants the display to one button for a fixed hold window and presents that button's press count (0-9) as the digit to show.

Parameters:
- CNT_W, 16, width of the debounce and hold counters.
- DEBOUNCE_CYCLES, 1000, consecutive cycles a synchronised input must differ from its stable value before the stable value flips. Legal range 1 to 2^CNT_W-1.
- HOLD_CYCLES, 5000, cycles the display stays owned by the granted button. Legal range 1 to 2^CNT_W-1.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- btn_raw, input, 4, asynchronous raw button levels; bit i is button i.
- grant, output, 4, one-hot, high for exactly one cycle when button i wins arbitration.
- active_btn, output, 2, index of the button owning the display.
- digit, output, 4, value for the seg7 decoder, always in the range 0-9.
- seg_en, output, 1, display enable; high while in SHOW.
- busy, output, 1, high whenever the FSM is not in IDLE.
- drop_flag, output, 1, sticky; a press arrived while that button's pending bit was already set.

Behaviour:
- Reset (clk edge with rst=1): all outputs 0; FSM to IDLE; sync flops, stable levels, debounce counters, pending bits, per-button press counters and RR pointer all 0. Reset mid-SHOW aborts the window immediately.
- Sync: 2-flop synchroniser per bit, giving btn_s.
- Debounce, per bit:
  - If btn_s != stable, cnt increments.
  - If btn_s == stable, cnt clears to 0.
  - When cnt reaches DEBOUNCE_CYCLES-1 while still differing, stable flips and cnt clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) is ignored.
- Press event: stable 0->1 sets pending[i] on the next edge.
  - If pending[i] is already 1, set drop_flag instead; drop_flag is cleared only by rst.
  - Release (1->0) generates nothing.
- Latency: raw rising edge at cycle 0 with a clean level gives grant at cycle DEBOUNCE_CYCLES+4, provided the FSM is IDLE.
- FSM states:
  - IDLE: if any pending bit is set, choose a winner and go to GRANT. Otherwise stay.
  - GRANT (1 cycle): grant[w]=1; clear pending[w]; press_cnt[w] = (press_cnt[w]==9) ? 0 : press_cnt[w]+1; active_btn=w; RR pointer = w+1 mod 4; hold counter cleared; next state SHOW.
  - SHOW: seg_en=1; digit=press_cnt[active_btn]. After HOLD_CYCLES cycles in SHOW, return to IDLE.
- In IDLE: digit and active_btn hold their last values; seg_en=0.
- Arbitration: round-robin starting the search at the RR pointer. Among simultaneous pending bits, the first found at or after the pointer wins.
- During GRANT and SHOW:
  - New presses still set pending and are serviced after return to IDLE, so there is no loss up to one press per button.
  - A press on the active button during its own window pends normally.
  - The GRANT clear of pending[w] coincident with a new set of pending[w] resolves to set; the new press is kept and no drop is flagged.
- Wrap: press_cnt goes 9 -> 0; the RR pointer goes 3 -> 0.

Optional Feature:
- Macro: SEG7_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest pending index always wins; the RR pointer is not implemented.
- Undefined: round-robin exactly as described above.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8):
- Reset: rst high 3 cycles, btn_raw=4'hF -> all outputs 0. After rst low, button 0..3 grants follow in RR order.
- Clean press: btn_raw[0] 0->1 at cycle 0, held -> grant=4'b0001 at cycle 8; digit=1, seg_en=1 for 8 cycles; busy drops at cycle 17.
- Bounce: btn_raw[1] pulses high 2 cycles, low 2, high 3, low -> no grant. Then held high 10 cycles -> exactly one grant=4'b0010 and digit=1.
- Simultaneous: btn_raw[2] and btn_raw[3] rise together from reset -> grant 4'b0100 then 4'b1000, separated by 10 cycles. With SEG7_FIXED_PRIO_EN defined and button 0 also pressed, button 0 wins first.
- Wrap and drop: press button 0 ten times, spaced beyond the window -> digit sequence 1..9, then 0. Two clean presses of button 3 during another button's SHOW -> drop_flag=1, and only one grant for button 3.
- Reset mid-SHOW: assert rst 2 cycles into SHOW -> seg_en, busy, digit go to 0 next edge; pending cleared; no further grant.
